// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver: snapshots a page of hex nibbles from one
// of NSRC source words at each frame start and scans them out one digit at a time.
module seg7_scan_mux #(
    parameter int DIGITS     = 4,
    parameter int NSRC       = 4,
    parameter int DATA_W     = 32,
    parameter int REFRESH    = 50000,
    parameter int ACTIVE_LOW = 1,
    localparam int SEL_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC*DATA_W-1:0]   src_data,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [2:0]               page,
    input  logic                     hold,
    input  logic                     blank_lz,
    output logic [DIGITS-1:0]        enable,
    output logic [6:0]               led_out
);

    localparam int CNT_W  = $clog2(REFRESH);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SNAP_W = DIGITS * 4;
    localparam logic [DIGITS-1:0] EN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]         LED_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [DIGITS-1:0] enable_q, enable_d;
    logic [6:0]        led_q, led_d;

    logic              tick;
    logic              frame_start;
    logic [DATA_W-1:0] word_sel;
    logic [SNAP_W-1:0] cap_nib;
    logic [DIGITS-1:0] upper_zero;
    logic [3:0]        cur_nib;
    logic              blank;
    logic [DIGITS-1:0] onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick        = (cnt_q == CNT_W'(REFRESH - 1));
    assign frame_start = (cnt_q == '0) && (idx_q == '0);

    // Out-of-range selects fall through with the zero default.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                word_sel = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [DATA_W-1:0] shifted;
            // Shifting past the word width yields zero nibbles beyond DATA_W.
            assign shifted                = word_sel >> (4 * (int'(page) * DIGITS + gi));
            assign cap_nib[gi*4 +: 4]     = shifted[3:0];
            assign upper_zero[gi]         = ~|snap_q[SNAP_W-1:gi*4];
        end
    endgenerate

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        snap_d = snap_q;
        if (frame_start && !hold) begin
            snap_d = cap_nib;
        end
    end

    always_comb begin
        cur_nib  = snap_q[int'(idx_q)*4 +: 4];
        blank    = blank_lz && (idx_q != '0) && upper_zero[idx_q];
        onehot   = DIGITS'(1) << idx_q;
        enable_d = (ACTIVE_LOW != 0) ? ~onehot : onehot;
        led_d    = blank ? 7'h00 : hex_to_seg(cur_nib);
        if (ACTIVE_LOW != 0) begin
            led_d = ~led_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            snap_q   <= '0;
            enable_q <= EN_OFF;
            led_q    <= LED_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            enable_q <= enable_d;
            led_q    <= led_d;
        end
    end

    assign enable  = enable_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed test-plan frames plus randomized traffic, all
// checked against a frame-position model of the display.
module tb_seg7_scan_mux;

    localparam int DIGITS  = 4;
    localparam int NSRC    = 4;
    localparam int DATA_W  = 32;
    localparam int REFRESH = 4;
    localparam int FRAME   = DIGITS * REFRESH;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NSRC*DATA_W-1:0] src_data = '0;
    logic [1:0]             src_sel = '0;
    logic [2:0]             page = '0;
    logic                   hold = 1'b0;
    logic                   blank_lz = 1'b0;
    logic [DIGITS-1:0]      enable, enable3;
    logic [6:0]             led_out, led_out3;

    always #5 clk = ~clk;

    seg7_scan_mux #(.DIGITS(DIGITS), .NSRC(NSRC), .DATA_W(DATA_W), .REFRESH(REFRESH), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .src_data(src_data), .src_sel(src_sel), .page(page),
        .hold(hold), .blank_lz(blank_lz), .enable(enable), .led_out(led_out)
    );

    seg7_scan_mux #(.DIGITS(DIGITS), .NSRC(3), .DATA_W(DATA_W), .REFRESH(REFRESH), .ACTIVE_LOW(1)) dut3 (
        .clk(clk), .reset(reset), .src_data(src_data[3*DATA_W-1:0]), .src_sel(src_sel), .page(page),
        .hold(hold), .blank_lz(blank_lz), .enable(enable3), .led_out(led_out3)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int m_pos  = 0;
    int m_snap [2][DIGITS];
    logic [6:0]        exp_led [2];
    logic [DIGITS-1:0] exp_en  [2];
    logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cycle, obs, exp);
        end
    endtask

    // Nibble j of the page shown, for a display fed by nsrc source words.
    function automatic int capture_nib(int nsrc, int j);
        int p;
        logic [NSRC*DATA_W-1:0] sh;
        p = int'(page) * DIGITS + j;
        if (int'(src_sel) >= nsrc || p >= DATA_W / 4) return 0;
        sh = src_data >> (int'(src_sel) * DATA_W + 4 * p);
        return int'(sh[3:0]);
    endfunction

    function automatic logic [6:0] model_led(int w, int d);
        bit all_zero;
        all_zero = 1'b1;
        for (int i = d; i < DIGITS; i++) if (m_snap[w][i] != 0) all_zero = 1'b0;
        if (blank_lz && d > 0 && all_zero) return 7'h7F;
        return ~seg_hi[m_snap[w][d]];
    endfunction

    task automatic step();
        int d;
        @(posedge clk);
        cycle++;
        if (reset) begin
            m_pos = 0;
            for (int w = 0; w < 2; w++) begin
                for (int j = 0; j < DIGITS; j++) m_snap[w][j] = 0;
                exp_en[w]  = '1;
                exp_led[w] = 7'h7F;
            end
        end else begin
            d = m_pos / REFRESH;
            for (int w = 0; w < 2; w++) begin
                exp_en[w]  = ~(DIGITS'(1) << d);
                exp_led[w] = model_led(w, d);
            end
            if (m_pos == 0 && !hold) begin
                for (int j = 0; j < DIGITS; j++) begin
                    m_snap[0][j] = capture_nib(NSRC, j);
                    m_snap[1][j] = capture_nib(3, j);
                end
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        #1;
        check_eq("model_en", 32'(enable), 32'(exp_en[0]));
        check_eq("model_led", 32'(led_out), 32'(exp_led[0]));
        check_eq("model_en_nsrc3", 32'(enable3), 32'(exp_en[1]));
        check_eq("model_led_nsrc3", 32'(led_out3), 32'(exp_led[1]));
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < FRAME && m_pos != 0; i++) step();
        check_eq("frame_align", 32'(m_pos), 32'd0);
    endtask

    // Checks the remaining 15 cycles of a frame whose capture edge just passed.
    task automatic frame_check(input string tag, input logic [6:0] l0, input logic [6:0] l1,
                               input logic [6:0] l2, input logic [6:0] l3,
                               input int chg_k, input logic [31:0] chg_word);
        logic [6:0]        ls [4];
        logic [DIGITS-1:0] e;
        ls = '{l0, l1, l2, l3};
        check_eq({tag, "_align"}, 32'(m_pos), 32'd1);
        for (int k = 1; k < FRAME; k++) begin
            if (k == chg_k) src_data[31:0] = chg_word;
            step();
            e = ~(DIGITS'(1) << (k / REFRESH));
            check_eq({tag, "_en"}, 32'(enable), 32'(e));
            check_eq({tag, "_led"}, 32'(led_out), 32'(ls[k / REFRESH]));
        end
        $display("frame %s checked at cycle %0d", tag, cycle);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        src_data[31:0] = 32'h1234ABCD;
        repeat (3) begin
            step();
            check_eq("reset_en", 32'(enable), 32'hF);
            check_eq("reset_led", 32'(led_out), 32'h7F);
        end
        reset = 1'b0;
        step();
        check_eq("first_en", 32'(enable), 32'hE);
        check_eq("first_led", 32'(led_out), 32'h40);
        frame_check("abcd", 7'h21, 7'h46, 7'h03, 7'h08, 0, 32'h0);

        page = 3'd1;
        to_frame_start(); step();
        frame_check("page1", 7'h19, 7'h30, 7'h24, 7'h79, 0, 32'h0);

        page = 3'd2;
        to_frame_start(); step();
        frame_check("page2", 7'h40, 7'h40, 7'h40, 7'h40, 0, 32'h0);

        page = 3'd0;
        src_sel = 2'd3;
        src_data[127:96] = 32'h0000BEEF;
        to_frame_start(); step();
        for (int k = 1; k < FRAME; k++) begin
            step();
            check_eq("nsrc3_sel3_led", 32'(led_out3), 32'h40);
        end
        $display("frame nsrc3_sel3 checked at cycle %0d", cycle);

        src_sel = 2'd0;
        src_data[31:0] = 32'h00000012;
        blank_lz = 1'b1;
        to_frame_start(); step();
        frame_check("blank", 7'h24, 7'h79, 7'h7F, 7'h7F, 0, 32'h0);
        blank_lz = 1'b0;
        step();
        frame_check("noblank", 7'h24, 7'h79, 7'h40, 7'h40, 6, 32'h98765432);

        step();
        frame_check("newdata", 7'h24, 7'h30, 7'h19, 7'h12, 0, 32'h0);

        hold = 1'b1;
        src_data[31:0] = 32'h000000FF;
        step();
        frame_check("hold", 7'h24, 7'h30, 7'h19, 7'h12, 0, 32'h0);
        hold = 1'b0;
        step();
        frame_check("release", 7'h0E, 7'h0E, 7'h40, 7'h40, 0, 32'h0);

        to_frame_start(); step();
        repeat (8) step();
        check_eq("digit2_en", 32'(enable), 32'hB);
        reset = 1'b1;
        step();
        check_eq("midreset_en", 32'(enable), 32'hF);
        check_eq("midreset_led", 32'(led_out), 32'h7F);
        reset = 1'b0;
        step();
        check_eq("restart_en", 32'(enable), 32'hE);
        check_eq("restart_led", 32'(led_out), 32'h40);
        step();
        check_eq("restart_digit0_en", 32'(enable), 32'hE);
        $display("mid-scan reset checked at cycle %0d", cycle);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int w = 0; w < NSRC; w++) begin
                    src_data[w*DATA_W +: DATA_W] = $urandom() >> ($urandom_range(0, 7) * 4);
                end
            end
            if ($urandom_range(0, 15) == 0) src_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) page = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) blank_lz = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        $display("random phase done at cycle %0d", cycle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Parametrised, time-multiplexed seven-segment display driver for the single-cycle processor's debug display. It selects one of NSRC 32-bit processor words (instruction, ALU result, PC, memory data, …) and a page of DIGITS hex nibbles within it, then scans the digits at a programmable refresh rate. Frame-atomic snapshotting removes tearing. Hold, leading-zero blanking and selectable output polarity are added over the fixed 4-digit driver. It sits at the top level beside the core and drives the board's digit enables and segment lines.

## Interface
- DIGITS, 4: number of multiplexed digits (1–8).
- NSRC, 4: number of source words (≥1).
- DATA_W, 32: width of each source word, multiple of 4.
- REFRESH, 50000: clk cycles each digit stays active (≥2).
- ACTIVE_LOW, 1: 1 means enable and led_out are active-low; 0 means active-high.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- src_data  in  NSRC*DATA_W  source words; word k at bits [k*DATA_W +: DATA_W].
- src_sel  in  max(1,clog2(NSRC))  source index.
- page  in  3  nibble window; page p shows nibbles [p*DIGITS, p*DIGITS+DIGITS-1].
- hold  in  1  1 freezes the snapshot.
- blank_lz  in  1  1 enables leading-zero blanking.
- enable  out  DIGITS  one-hot digit enable; bit 0 is the rightmost (least significant) digit.
- led_out  out  7  segments {g,f,e,d,c,b,a}.

## Operation
- refresh counter cnt runs 0..REFRESH-1 and wraps. tick = (cnt == REFRESH-1).
- digit index idx advances modulo DIGITS on tick.
- Frame start is when cnt==0 and idx==0.
- At a frame-start edge with hold=0, snap ← the DIGITS nibbles of word src_data[src_sel] at page.
  - Nibbles beyond DATA_W read 0.
  - src_sel ≥ NSRC reads all 0.
- With hold=1 at frame start, snap is kept.
- src_sel, page and src_data changes mid-frame have no effect until the next frame start.
- Decode of nibble n = snap[idx]: standard hex 0–F. Active-high patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking: digit i (i>0) shows all segments off when blank_lz=1 and nibbles i..DIGITS-1 of snap are all 0. Digit 0 is never blanked.
- When ACTIVE_LOW=1, enable and led_out are the bitwise inverse of the active-high values.

## Timing
- enable and led_out are registered.
  - The value in cycle k+1 reflects idx, snap and blank_lz in cycle k, giving 1-cycle output latency.
- Reset values:
  - cnt=0, idx=0, snap=0.
  - enable all inactive (all 1s when ACTIVE_LOW=1).
  - led_out all off (7'h7F when ACTIVE_LOW=1).
- The first cycle after reset release is a frame start, so snap loads on that edge.
  - Outputs in that first cycle show digit 0 of the reset snap, "0".
  - The captured value appears from the following cycle.
- Each digit is active for exactly REFRESH consecutive cycles. One frame is DIGITS*REFRESH cycles.
- Exactly one enable bit is active whenever reset is low (after the first output cycle).
- Reset asserted mid-scan returns all state and outputs to reset values at that edge, regardless of hold.
- hold and frame start in the same cycle: hold wins, no capture.
- blank_lz is sampled every cycle, so it takes effect within 1 cycle, not at frame boundaries.

## Test plan
Parameters for all scenarios: DIGITS=4, REFRESH=4, NSRC=4, ACTIVE_LOW=1.
- Reset held 3 cycles -> enable=4'b1111, led_out=7'h7F every cycle. Release -> enable=4'b1110, led_out=7'h40 ("0") in the first cycle.
- src_data[0]=32'h1234ABCD, src_sel=0, page=0 -> digits 0..3 show d,C,b,A:
  - digit 0: enable 4'b1110 with led_out 7'h21 ("d"), for 4 cycles.
  - then digit 1: 4'b1101 with 7'h46 ("C").
  - then 4'b1011 with 7'h03, then 4'b0111 with 7'h08; the 16-cycle frame repeats.
- Same setup with page=1 -> 4,3,2,1 shown. page=2 -> "0000". src_sel=3 with NSRC=3 -> "0000".
- src_data[0]=32'h00000012, blank_lz=1 -> digit 0 "2" (7'h24), digit 1 "1" (7'h79), digits 2 and 3 led_out=7'h7F. blank_lz=0 -> digits 2 and 3 show "0".
- Change src_data in the middle of a frame -> displayed digits keep old values until the next frame start.
- hold=1 across a frame start with new data -> old value persists. Release hold -> new value appears from the next frame.
- Assert reset for 1 cycle during digit 2 -> next cycle enable=4'b1111, led_out=7'h7F; scanning restarts at digit 0.
